cmd_proc: RTL

Downstream consumer of the RS232 interface's 32-bit command FIFO and producer into its 32-bit response FIFO.
- Pops one binary command word, decodes it and performs a register read or write on a simple req/ack register bus.
- Pushes exactly one 32-bit response word per command.
- Bridges the host serial link to the design's control/status registers.

---
 rtl/cmd_proc_pkg.sv | 59 +++++
 rtl/cmd_proc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cmd_proc_pkg
//  Purpose : Shared definitions for the command processor: opcodes, response
//            status codes, FSM state encoding, and the bit positions of the
//            fields inside command and response words.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cmd_proc_pkg;

    // Opcodes carried in command word [31:24]
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    // Status codes carried in response word [31:24]
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BADOP   = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;

    // Command word fields
    localparam int CMD_OP_MSB   = 31;
    localparam int CMD_OP_LSB   = 24;
    localparam int CMD_ADDR_MSB = 23;
    localparam int CMD_ADDR_LSB = 16;
    localparam int CMD_DATA_MSB = 15;
    localparam int CMD_DATA_LSB = 0;

    // Response word fields
    localparam int RSP_ST_MSB   = 31;
    localparam int RSP_ST_LSB   = 24;
    localparam int RSP_ADDR_MSB = 23;
    localparam int RSP_ADDR_LSB = 16;
    localparam int RSP_DATA_MSB = 15;
    localparam int RSP_DATA_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LATCH = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Assemble a response word from its three fields
    function automatic logic [31:0] pack_rsp(input logic [7:0]  status,
                                             input logic [7:0]  addr,
                                             input logic [15:0] data);
        logic [31:0] w;
        w                           = '0;
        w[RSP_ST_MSB:RSP_ST_LSB]     = status;
        w[RSP_ADDR_MSB:RSP_ADDR_LSB] = addr;
        w[RSP_DATA_MSB:RSP_DATA_LSB] = data;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_proc.sv
`default_nettype none
// ============================================================================
//  Module  : cmd_proc
//  Purpose : Pops 32-bit commands from the serial-link command FIFO, performs
//            the register read/write they describe on a req/ack register bus,
//            and pushes exactly one 32-bit response per command.
//  Ports   :
//    clk, rst          clock, synchronous active-high reset
//    cmd_fifo_*        command FIFO read side (standard, non-FWFT)
//    rsp_fifo_*        response FIFO write side
//    reg_*             register bus (level requests, one-cycle ack)
//    busy              high whenever the FSM is not idle
//  Options :
//    CMD_PROC_TIMEOUT_EN  when defined, a bus request with no reg_ack for
//                         P_TIMEOUT_CYCLES cycles is aborted with status 0x02
//  Rev     : 1.0  initial release
// ============================================================================
module cmd_proc
    import cmd_proc_pkg::*;
#(
    parameter int P_TIMEOUT_CYCLES = 1024,
    parameter int P_TMO_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_fifo_dout,
    output logic        cmd_fifo_rd_en,
    input  logic        cmd_fifo_empty,
    output logic [31:0] rsp_fifo_din,
    output logic        rsp_fifo_wr_en,
    input  logic        rsp_fifo_full,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    input  logic        reg_ack,
    output logic        busy
);

    // The timeout counter must be able to hold the timeout value
    if (P_TMO_W < $clog2(P_TIMEOUT_CYCLES + 1)) begin : g_tmo_w_check
        $error("cmd_proc: P_TMO_W too narrow for P_TIMEOUT_CYCLES");
    end

    state_t      state_q,     state_d;
    logic [31:0] cmd_q,       cmd_d;
    logic        rd_en_q,     rd_en_d;
    logic        wr_en_q,     wr_en_d;
    logic [31:0] rsp_din_q,   rsp_din_d;
    logic [7:0]  reg_addr_q,  reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        reg_wr_q,    reg_wr_d;
    logic        reg_rd_q,    reg_rd_d;
    logic        busy_q,      busy_d;

`ifdef CMD_PROC_TIMEOUT_EN
    localparam logic [P_TMO_W-1:0] C_TMO_LAST = P_TMO_W'(P_TIMEOUT_CYCLES - 1);
    logic [P_TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Fields of the word presented by the FIFO during LATCH
    logic [7:0]  w_in_op;
    logic [7:0]  w_in_addr;
    logic [15:0] w_in_data;
    // Fields of the latched command used while on the bus
    logic [7:0]  w_cmd_op;
    logic [7:0]  w_cmd_addr;
    logic [15:0] w_cmd_data;

    assign w_in_op    = cmd_fifo_dout[CMD_OP_MSB:CMD_OP_LSB];
    assign w_in_addr  = cmd_fifo_dout[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_in_data  = cmd_fifo_dout[CMD_DATA_MSB:CMD_DATA_LSB];
    assign w_cmd_op   = cmd_q[CMD_OP_MSB:CMD_OP_LSB];
    assign w_cmd_addr = cmd_q[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_cmd_data = cmd_q[CMD_DATA_MSB:CMD_DATA_LSB];

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        rsp_din_d   = rsp_din_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = reg_wr_q;
        reg_rd_d    = reg_rd_q;
`ifdef CMD_PROC_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        // Outputs are registered, so each pulse is raised on the transition
        // into the state that owns it. The push is requested on entry to RESP
        // when room is already available, giving the 2-cycle rd_en->wr_en gap.
        case (state_q)
            S_IDLE: begin
                if (!cmd_fifo_empty) begin
                    state_d = S_POP;
                    rd_en_d = 1'b1;
                end
            end

            S_POP: begin
                state_d = S_LATCH;
            end

            S_LATCH: begin
                cmd_d = cmd_fifo_dout;
                case (w_in_op)
                    OP_NOP: begin
                        rsp_din_d = pack_rsp(ST_OK, w_in_addr, w_in_data);
                        state_d   = S_RESP;
                        wr_en_d   = !rsp_fifo_full;
                    end
                    OP_WRITE, OP_READ: begin
                        reg_addr_d  = w_in_addr;
                        reg_wdata_d = w_in_data;
                        reg_wr_d    = (w_in_op == OP_WRITE);
                        reg_rd_d    = (w_in_op == OP_READ);
                        state_d     = S_BUS;
`ifdef CMD_PROC_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end
                    default: begin
                        rsp_din_d = pack_rsp(ST_BADOP, w_in_addr, 16'h0000);
                        state_d   = S_RESP;
                        wr_en_d   = !rsp_fifo_full;
                    end
                endcase
            end

            S_BUS: begin
                // Ack is checked first so an ack on the expiry cycle wins
                if (reg_ack) begin
                    reg_wr_d  = 1'b0;
                    reg_rd_d  = 1'b0;
                    rsp_din_d = pack_rsp(ST_OK, w_cmd_addr,
                                         (w_cmd_op == OP_READ) ? reg_rdata : w_cmd_data);
                    state_d   = S_RESP;
                    wr_en_d   = !rsp_fifo_full;
                end
`ifdef CMD_PROC_TIMEOUT_EN
                else if (tmo_q == C_TMO_LAST) begin
                    reg_wr_d  = 1'b0;
                    reg_rd_d  = 1'b0;
                    rsp_din_d = pack_rsp(ST_TIMEOUT, w_cmd_addr, 16'h0000);
                    state_d   = S_RESP;
                    wr_en_d   = !rsp_fifo_full;
                end else begin
                    tmo_d = tmo_q + P_TMO_W'(1);
                end
`endif
            end

            S_RESP: begin
                if (wr_en_q) begin
                    state_d = S_IDLE;
                end else if (!rsp_fifo_full) begin
                    wr_en_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_din_q   <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CMD_PROC_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rsp_din_q   <= rsp_din_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
`ifdef CMD_PROC_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign cmd_fifo_rd_en = rd_en_q;
    assign rsp_fifo_wr_en = wr_en_q;
    assign rsp_fifo_din   = rsp_din_q;
    assign reg_addr       = reg_addr_q;
    assign reg_wdata      = reg_wdata_q;
    assign reg_wr         = reg_wr_q;
    assign reg_rd         = reg_rd_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire
